// File: rtl/psum_writeback_buffer_if.sv
// Bus bundle between the PE-array psum path, the AXI write master FSM and the
// writeback buffer. "master" is the buffer's view, "slave" the environment's.
interface psum_writeback_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  START;
    logic [ADDR_WIDTH-1:0] OUTPUT_BASE_ADDR;
    logic                  FLUSH;
    logic [DATA_WIDTH-1:0] PSUM_IN;
    logic                  PSUM_VALID;
    logic                  PSUM_READY;
    logic [ADDR_WIDTH-1:0] M_TARGET_SLAVE_BASE_AW_ADDR;
    logic                  INIT_AXI_WR_TXN;
    logic [DATA_WIDTH-1:0] M_AXI_WDATA;
    logic                  M_AXI_WVALID_WREADY;
    logic                  TXN_DONE;
    logic                  AXI_ERROR;
    logic                  BUSY;
    logic                  DONE;
    logic                  ERROR;
    logic [31:0]           WORDS_WRITTEN;

    modport master (
        input  START, OUTPUT_BASE_ADDR, FLUSH, PSUM_IN, PSUM_VALID,
               M_AXI_WVALID_WREADY, TXN_DONE, AXI_ERROR,
        output PSUM_READY, M_TARGET_SLAVE_BASE_AW_ADDR, INIT_AXI_WR_TXN,
               M_AXI_WDATA, BUSY, DONE, ERROR, WORDS_WRITTEN
    );

    modport slave (
        output START, OUTPUT_BASE_ADDR, FLUSH, PSUM_IN, PSUM_VALID,
               M_AXI_WVALID_WREADY, TXN_DONE, AXI_ERROR,
        input  PSUM_READY, M_TARGET_SLAVE_BASE_AW_ADDR, INIT_AXI_WR_TXN,
               M_AXI_WDATA, BUSY, DONE, ERROR, WORDS_WRITTEN
    );
endinterface

// File: rtl/psum_writeback_buffer.sv
// Buffers output psums in a FIFO and feeds fixed-length AXI write bursts to
// consecutive addresses; a flush drains the remainder as a zero-padded burst.
module psum_writeback_buffer #(
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M00_AXI_BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH           = 32,
    parameter int unsigned ADDR_WIDTH           = 32
) (
    input logic                     CLK,
    input logic                     RESET,
    psum_writeback_buffer_if.master bus
);
    localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned BEAT_W      = (C_M00_AXI_BURST_LEN > 1) ? $clog2(C_M00_AXI_BURST_LEN) : 1;
    localparam int unsigned BURST_BYTES = C_M00_AXI_BURST_LEN * (C_M00_AXI_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_INIT, S_WRITE, S_WAIT_DONE, S_DONE, S_ERR
    } state_t;

    state_t                          state, state_nxt;
    logic [C_M00_AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr, rd_ptr;
    logic [CNT_W-1:0]                count;
    logic [BEAT_W-1:0]               beat;
    logic                            flush_pending;
    logic [ADDR_WIDTH-1:0]           addr;
    logic [31:0]                     words_written;

    logic full, empty, busy, push, pop, beat_fire, abort_err;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state inside {S_COLLECT, S_INIT, S_WRITE, S_WAIT_DONE});
    assign abort_err = bus.AXI_ERROR && (state inside {S_INIT, S_WRITE, S_WAIT_DONE});
    assign push      = bus.PSUM_VALID && bus.PSUM_READY;
    assign beat_fire = (state == S_WRITE) && bus.M_AXI_WVALID_WREADY && !bus.AXI_ERROR;
    // Pad beats are exactly the beats taken while the FIFO is empty.
    assign pop       = beat_fire && !empty;

    assign bus.PSUM_READY                  = !full && busy && !flush_pending;
    assign bus.INIT_AXI_WR_TXN             = (state == S_INIT);
    assign bus.M_AXI_WDATA                 = (state == S_WRITE && !empty) ? mem[rd_ptr] : '0;
    assign bus.M_TARGET_SLAVE_BASE_AW_ADDR = addr;
    assign bus.BUSY                        = busy;
    assign bus.DONE                        = (state == S_DONE);
    assign bus.ERROR                       = (state == S_ERR);
    assign bus.WORDS_WRITTEN               = words_written;

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: begin
                if (count >= CNT_W'(C_M00_AXI_BURST_LEN)) state_nxt = S_INIT;
                else if (flush_pending)                  state_nxt = empty ? S_DONE : S_INIT;
            end
            S_INIT:      state_nxt = S_WRITE;
            S_WRITE:     if (beat_fire && beat == BEAT_W'(C_M00_AXI_BURST_LEN - 1)) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.TXN_DONE) state_nxt = S_COLLECT;
            default:     state_nxt = state;
        endcase
        if (abort_err) state_nxt = S_ERR;
        // START from any state restarts the job.
        if (bus.START) state_nxt = S_COLLECT;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            beat          <= '0;
            flush_pending <= 1'b0;
            addr          <= '0;
            words_written <= '0;
        end else if (bus.START) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            beat          <= '0;
            flush_pending <= 1'b0;
            addr          <= bus.OUTPUT_BASE_ADDR;
            words_written <= '0;
        end else if (abort_err) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (bus.FLUSH && busy) flush_pending <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (state == S_INIT)  beat <= '0;
            else if (beat_fire)   beat <= beat + BEAT_W'(1);
            if (pop) words_written <= words_written + 32'd1;
            if (state == S_WAIT_DONE && bus.TXN_DONE) addr <= addr + ADDR_WIDTH'(BURST_BYTES);
        end
    end

    // Storage needs no reset; reads are gated by the occupancy count.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= bus.PSUM_IN;
    end
endmodule
